// File: rtl/dds_pkg.sv
// Shared encodings and reset-value helpers for the DDS waveform generator.
package dds_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SQUARE = 2'd3
    } mode_e;

    // Tuning word giving one table step per clk.
    function automatic logic [63:0] reset_ftw(input int unsigned phase_w,
                                              input int unsigned addr_w);
        return 64'd1 << (phase_w - addr_w);
    endfunction

    // Offset-binary zero level.
    function automatic logic [63:0] midscale(input int unsigned data_w);
        return 64'd1 << (data_w - 1);
    endfunction

    // Amplitude code for gain 1.0.
    function automatic logic [63:0] unity_amp(input int unsigned data_w);
        return 64'd1 << data_w;
    endfunction

endpackage

// File: rtl/wave_rom.sv
// Sine lookup table with a registered read port; the output register is stage 1 for SINE.
// Contents come from an integer sine approximation evaluated at elaboration, so the table
// synthesises to constant logic. An empty INIT_FILE selects a flat midscale table.
module wave_rom #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 8,
    parameter string       INIT_FILE = "sine.mif"
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] q
);
    import dds_pkg::*;

    localparam int unsigned       Depth     = 1 << ADDR_W;
    localparam int unsigned       Half      = Depth / 2;
    localparam logic [DATA_W-1:0] Mid       = DATA_W'(midscale(DATA_W));
    localparam bit                FlatTable = (INIT_FILE == "");

    // Bhaskara approximation of sin over each half period, rounded to nearest.
    function automatic logic [DATA_W-1:0] sine_entry(input int unsigned idx);
        longint n, t, y, a, num, den, mag;
        n   = longint'(Half);
        t   = longint'(idx) % n;
        y   = t * (n - t);
        a   = (longint'(1) << (DATA_W - 1)) - 1;
        num = 16 * a * y;
        den = 5 * n * n - 4 * y;
        mag = (num + den / 2) / den;
        return (idx < Half) ? Mid + DATA_W'(mag) : Mid - DATA_W'(mag);
    endfunction

    logic [DATA_W-1:0] rom_mem [Depth];

    for (genvar i = 0; i < Depth; i++) begin : g_rom
        assign rom_mem[i] = FlatTable ? Mid : sine_entry(i);
    end

    // Registered read, advancing only when the pipeline does.
    always_ff @(posedge clk) begin
        if (en) q <= rom_mem[addr];
    end

endmodule

// File: rtl/dds_wavegen.sv
// Direct-digital-synthesis waveform generator: phase accumulator, waveform stage,
// amplitude scaling with saturation, shadowed config applied at period boundaries.
module dds_wavegen
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_W   = 24,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 8,
    parameter string       INIT_FILE = "sine.mif"
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sync,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [ADDR_W-1:0]  cfg_poff,
    input  logic [1:0]         cfg_mode,
    input  logic [DATA_W:0]    cfg_amp,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    output logic               wrap
);

    localparam int unsigned        ProdW    = 2 * DATA_W + 3;
    localparam logic [PHASE_W-1:0] FtwReset = PHASE_W'(reset_ftw(PHASE_W, ADDR_W));
    localparam logic [DATA_W-1:0]  Mid      = DATA_W'(midscale(DATA_W));
    localparam logic [DATA_W:0]    AmpUnity = (DATA_W + 1)'(unity_amp(DATA_W));
    localparam logic [DATA_W-1:0]  Max      = '1;

    typedef struct packed {
        logic [PHASE_W-1:0] ftw;
        logic [ADDR_W-1:0]  poff;
        mode_e              mode;
        logic [DATA_W:0]    amp;
    } cfg_t;

    localparam cfg_t CfgReset = '{ftw: FtwReset, poff: '0, mode: MODE_SINE, amp: AmpUnity};

    cfg_t               cfg_q, shadow_q, cfg_in;
    logic               shadow_full_q;
    logic [PHASE_W-1:0] acc_q, acc_d, acc_sum;
    logic               wrap_pend_q, wrap_pend_d;
    logic               carry, take, apply;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  raw, rom_q;

    logic               s1_valid_q, s1_wrap_q;
    mode_e              s1_mode_q;
    logic [DATA_W:0]    s1_amp_q;
    logic [DATA_W-1:0]  s1_raw_q;

    logic [DATA_W-1:0]  src, sample_d, sample_q;
    logic               sample_valid_q, wrap_q;
    logic signed [DATA_W:0]  centred;
    logic signed [ProdW-1:0] prod, shifted, scaled;

    assign cfg_in = '{ftw: cfg_ftw, poff: cfg_poff, mode: mode_e'(cfg_mode), amp: cfg_amp};

    assign addr             = acc_q[PHASE_W-1 -: ADDR_W] + cfg_q.poff;
    assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, cfg_q.ftw};
    assign take             = cfg_valid && !shadow_full_q;
    // Running: switch only at a period boundary so no period is cut short.
    assign apply            = shadow_full_q && (sync || !en || carry);
    assign cfg_ready        = !shadow_full_q;

    // Accumulator advance; the carry (or a sync) tags the next phase as a new period.
    always_comb begin
        acc_d       = acc_q;
        wrap_pend_d = wrap_pend_q;
        if (sync) begin
            acc_d       = '0;
            wrap_pend_d = 1'b1;
        end else if (en) begin
            acc_d       = acc_sum;
            wrap_pend_d = carry;
        end
    end

    // Phase state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            wrap_pend_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            wrap_pend_q <= wrap_pend_d;
        end
    end

    // Config shadow capture and atomic application of all fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_q         <= CfgReset;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            if (apply) begin
                cfg_q         <= shadow_q;
                shadow_full_q <= 1'b0;
            end
            if (take) begin
                shadow_q      <= cfg_in;
                shadow_full_q <= 1'b1;
            end
        end
    end

    // Arithmetic waveforms; SINE comes from the ROM register instead.
    always_comb begin
        raw = '0;
        case (cfg_q.mode)
            MODE_SAW:    raw = addr[ADDR_W-1 -: DATA_W];
            MODE_TRI:    raw = addr[ADDR_W-1] ? ~addr[ADDR_W-2 -: DATA_W]
                                              : addr[ADDR_W-2 -: DATA_W];
            MODE_SQUARE: raw = addr[ADDR_W-1] ? '0 : Max;
            default:     raw = '0;
        endcase
    end

    wave_rom #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clk  (clk),
        .en   (en),
        .addr (addr),
        .q    (rom_q)
    );

    // Stage 1: raw sample plus the attributes that travel with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_wrap_q  <= 1'b0;
            s1_mode_q  <= MODE_SINE;
            s1_amp_q   <= '0;
            s1_raw_q   <= '0;
        end else begin
            s1_valid_q <= en;
            if (en) begin
                s1_wrap_q <= wrap_pend_q;
                s1_mode_q <= cfg_q.mode;
                s1_amp_q  <= cfg_q.amp;
                s1_raw_q  <= raw;
            end
        end
    end

    // Stage 2 datapath: centre, scale (floor via arithmetic shift), re-bias, saturate.
    always_comb begin
        src      = (s1_mode_q == MODE_SINE) ? rom_q : s1_raw_q;
        centred  = $signed({1'b0, src}) - $signed({1'b0, Mid});
        prod     = ProdW'(centred) * ProdW'($signed({1'b0, s1_amp_q}));
        shifted  = prod >>> DATA_W;
        scaled   = shifted + $signed(ProdW'(Mid));
        sample_d = scaled[DATA_W-1:0];
        if (scaled[ProdW-1]) begin
            sample_d = '0;
        end else if (scaled > $signed(ProdW'(Max))) begin
            sample_d = Max;
        end
    end

    // Stage 2 output register; sample holds while the pipeline is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q       <= Mid;
            sample_valid_q <= 1'b0;
            wrap_q         <= 1'b0;
        end else begin
            sample_valid_q <= s1_valid_q;
            wrap_q         <= s1_valid_q && s1_wrap_q;
            if (s1_valid_q) sample_q <= sample_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign wrap         = wrap_q;

endmodule

// File: tb/tb_dds_wavegen.sv
// Self-checking bench for dds_wavegen: scripted scenarios plus randomized traffic,
// compared against a behavioural cycle model built from the waveform rules.
module tb_dds_wavegen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, sync = 1'b0, cfg_valid = 1'b0;
    logic [23:0] cfg_ftw = '0;
    logic [9:0]  cfg_poff = '0;
    logic [1:0]  cfg_mode = '0;
    logic [8:0]  cfg_amp = '0;
    logic        cfg_ready, sample_valid, wrap;
    logic [7:0]  sample;

    int vectors = 0;
    int miscompares = 0;

    dds_wavegen #(
        .PHASE_W   (24),
        .ADDR_W    (10),
        .DATA_W    (8),
        .INIT_FILE ("sine.mif")
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sync         (sync),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ftw      (cfg_ftw),
        .cfg_poff     (cfg_poff),
        .cfg_mode     (cfg_mode),
        .cfg_amp      (cfg_amp),
        .sample       (sample),
        .sample_valid (sample_valid),
        .wrap         (wrap)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    longint m_acc;
    int     m_ftw, m_poff, m_mode, m_amp;
    int     s_ftw, s_poff, s_mode, s_amp;
    bit     m_sh_full, m_wrap_pend;
    bit     m_s1_valid, m_s1_wrap;
    int     m_s1_sample;
    bit     m_valid, m_wrap;
    int     m_sample;          // -1: sine value, not predicted

    // Expected output for one table position; -1 for SINE.
    function automatic int exp_sample(int mode, int p, int amp);
        int raw, v;
        case (mode)
            1:       raw = p / 4;
            2:       raw = (p < 512) ? (p % 512) / 2 : 255 - (p % 512) / 2;
            3:       raw = (p < 512) ? 255 : 0;
            default: return -1;
        endcase
        v = (raw - 128) * amp;
        v = (v >= 0) ? v / 256 : -((-v + 255) / 256);
        v = v + 128;
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic int model_p();
        return int'(((m_acc >> 14) + longint'(m_poff)) % 1024);
    endfunction

    task automatic model_reset();
        m_acc = 0; m_ftw = 1 << 14; m_poff = 0; m_mode = 0; m_amp = 256;
        m_sh_full = 0; m_wrap_pend = 0; m_s1_valid = 0; m_s1_wrap = 0; m_s1_sample = 0;
        m_valid = 0; m_wrap = 0; m_sample = 128;
    endtask

    // Advance model and DUT by one clk; returns at posedge+1.
    task automatic tick();
        longint sum;
        bit carry, apply, take;
        m_valid = m_s1_valid;
        m_wrap  = m_s1_valid && m_s1_wrap;
        if (m_s1_valid) m_sample = m_s1_sample;
        sum   = m_acc + longint'(m_ftw);
        carry = (sum >= (longint'(1) << 24));
        if (en) begin
            m_s1_sample = exp_sample(m_mode, model_p(), m_amp);
            m_s1_wrap   = m_wrap_pend;
        end
        m_s1_valid = en;
        apply = m_sh_full && (sync || !en || carry);
        take  = cfg_valid && !m_sh_full;
        if (sync) begin
            m_acc = 0; m_wrap_pend = 1;
        end else if (en) begin
            m_acc = sum % (longint'(1) << 24); m_wrap_pend = carry;
        end
        if (apply) begin
            m_ftw = s_ftw; m_poff = s_poff; m_mode = s_mode; m_amp = s_amp; m_sh_full = 0;
        end
        if (take) begin
            s_ftw = int'(cfg_ftw); s_poff = int'(cfg_poff); s_mode = int'(cfg_mode);
            s_amp = int'(cfg_amp); m_sh_full = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input int ftw, input int poff, input int mode, input int amp);
        cfg_valid = 1'b1;
        cfg_ftw = 24'(ftw); cfg_poff = 10'(poff); cfg_mode = 2'(mode); cfg_amp = 9'(amp);
        tick();
        cfg_valid = 1'b0;
    endtask

    // Stop, load a config, and restart from phase 0 via sync.
    task automatic restart(input int ftw, input int poff, input int mode, input int amp);
        en = 1'b0;
        tick();
        tick();
        do_cfg(ftw, poff, mode, amp);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (sample !== 8'h80 || sample_valid !== 1'b0 || wrap !== 1'b0 || cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: got s=%h v=%b w=%b r=%b, want s=80 v=0 w=0 r=1",
                     sample, sample_valid, wrap, cfg_ready);
        end
        rst = 1'b1;
    endtask

    task automatic test_saw(input string tag);
        int first_valid = -1, idx = 0, wraps = 0, wrap_idx = -1, s3 = -1, s4 = -1, s1023 = -1;
        en = 1'b0;
        do_cfg(1 << 14, 0, 1, 256);
        tick();
        en = 1'b1;
        for (int c = 0; c < 1032; c++) begin
            tick();
            vectors++;
            if (sample_valid !== m_valid || wrap !== m_wrap || cfg_ready !== !m_sh_full ||
                (m_sample >= 0 && sample !== 8'(m_sample))) begin
                miscompares++;
                $display("FAIL %s cyc %0d: got v=%b w=%b r=%b s=%h, want v=%b w=%b r=%b s=%h",
                         tag, c, sample_valid, wrap, cfg_ready, sample,
                         m_valid, m_wrap, !m_sh_full, m_sample);
            end
            if (sample_valid) begin
                if (first_valid < 0) first_valid = c;
                if (wrap) begin wraps++; wrap_idx = idx; end
                if (idx == 3)    s3 = int'(sample);
                if (idx == 4)    s4 = int'(sample);
                if (idx == 1023) s1023 = int'(sample);
                idx++;
            end
        end
        vectors++;
        if (first_valid !== 1) begin
            miscompares++;
            $display("FAIL %s latency: got first valid at tick %0d, want 1", tag, first_valid);
        end
        vectors++;
        if (wraps !== 1 || wrap_idx !== 1024) begin
            miscompares++;
            $display("FAIL %s wrap: got %0d wraps at %0d, want 1 at 1024", tag, wraps, wrap_idx);
        end
        vectors++;
        if (s3 !== 0 || s4 !== 1 || s1023 !== 255) begin
            miscompares++;
            $display("FAIL %s values: got [3]=%0d [4]=%0d [1023]=%0d, want 0 1 255",
                     tag, s3, s4, s1023);
        end
    endtask

    task automatic test_square();
        int amps [2] = '{256, 128};
        int his  [2] = '{255, 191};
        int los  [2] = '{0, 64};
        for (int k = 0; k < 2; k++) begin
            int idx = 0, n_hi = 0, n_lo = 0;
            restart(1 << 15, 0, 3, amps[k]);
            for (int c = 0; c < 516; c++) begin
                tick();
                vectors++;
                if (sample_valid !== m_valid || wrap !== m_wrap || cfg_ready !== !m_sh_full ||
                    (m_sample >= 0 && sample !== 8'(m_sample))) begin
                    miscompares++;
                    $display("FAIL square cyc %0d: got v=%b w=%b r=%b s=%h, want v=%b w=%b r=%b s=%h",
                             c, sample_valid, wrap, cfg_ready, sample,
                             m_valid, m_wrap, !m_sh_full, m_sample);
                end
                if (sample_valid && idx < 512) begin
                    if (int'(sample) == his[k]) n_hi++;
                    if (int'(sample) == los[k]) n_lo++;
                    idx++;
                end
            end
            vectors++;
            if (n_hi !== 256 || n_lo !== 256) begin
                miscompares++;
                $display("FAIL square amp %0d: got %0d high %0d low, want 256 256",
                         amps[k], n_hi, n_lo);
            end
        end
    endtask

    task automatic test_tri();
        int idx = 0;
        int got [1024];
        restart(1 << 14, 0, 2, 256);
        for (int c = 0; c < 1028; c++) begin
            tick();
            vectors++;
            if (sample_valid !== m_valid || wrap !== m_wrap || cfg_ready !== !m_sh_full ||
                (m_sample >= 0 && sample !== 8'(m_sample))) begin
                miscompares++;
                $display("FAIL tri cyc %0d: got v=%b w=%b r=%b s=%h, want v=%b w=%b r=%b s=%h",
                         c, sample_valid, wrap, cfg_ready, sample,
                         m_valid, m_wrap, !m_sh_full, m_sample);
            end
            if (sample_valid && idx < 1024) begin
                got[idx] = int'(sample);
                idx++;
            end
        end
        vectors++;
        if (got[0] !== 0 || got[510] !== 255 || got[511] !== 255 || got[512] !== 255 ||
            got[1023] !== 0) begin
            miscompares++;
            $display("FAIL tri points: got %0d %0d %0d %0d %0d, want 0 255 255 255 0",
                     got[0], got[510], got[511], got[512], got[1023]);
        end
    endtask

    task automatic test_handshake();
        int t_ready = -1, t_w1 = -1, t_w2 = -1, prev = -1, before_wrap = -1;
        bit was_ready = 1'b0;
        restart(1 << 14, 0, 1, 256);
        for (int c = 0; c < 2000 && model_p() != 100; c++) begin
            tick();
        end
        vectors++;
        if (model_p() != 100) begin
            miscompares++;
            $display("FAIL handshake reach: got p=%0d, want 100", model_p());
        end
        do_cfg(1 << 15, 0, 1, 256);
        vectors++;
        if (cfg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL handshake busy: got cfg_ready=%b, want 0", cfg_ready);
        end
        // Second offer while busy must be ignored.
        cfg_valid = 1'b1; cfg_ftw = 24'h002000; cfg_mode = 2'd2;
        tick();
        cfg_valid = 1'b0;
        for (int c = 0; c < 1700 && t_w2 < 0; c++) begin
            tick();
            vectors++;
            if (sample_valid !== m_valid || wrap !== m_wrap || cfg_ready !== !m_sh_full ||
                (m_sample >= 0 && sample !== 8'(m_sample))) begin
                miscompares++;
                $display("FAIL handshake cyc %0d: got v=%b w=%b r=%b s=%h, want v=%b w=%b r=%b s=%h",
                         c, sample_valid, wrap, cfg_ready, sample,
                         m_valid, m_wrap, !m_sh_full, m_sample);
            end
            if (cfg_ready && !was_ready && t_ready < 0) t_ready = c;
            was_ready = cfg_ready;
            if (sample_valid && wrap) begin
                if (t_w1 < 0) begin t_w1 = c; before_wrap = prev; end
                else t_w2 = c;
            end
            if (sample_valid) prev = int'(sample);
        end
        vectors++;
        if (t_w2 - t_w1 !== 512 || t_w1 < 0) begin
            miscompares++;
            $display("FAIL handshake period: got wraps at %0d %0d, want 512 apart", t_w1, t_w2);
        end
        vectors++;
        if (t_ready !== t_w1 - 2 || before_wrap !== 255) begin
            miscompares++;
            $display("FAIL handshake switch: got ready@%0d wrap@%0d last old=%0d, want ready=wrap-2 last=255",
                     t_ready, t_w1, before_wrap);
        end
    endtask

    task automatic test_sync();
        int wraps = 0;
        restart(1 << 14, 256, 1, 256);
        for (int c = 0; c < 2000 && model_p() != 300; c++) begin
            tick();
        end
        vectors++;
        if (model_p() != 300) begin
            miscompares++;
            $display("FAIL sync reach: got p=%0d, want 300", model_p());
        end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (sample_valid !== m_valid || wrap !== m_wrap || cfg_ready !== !m_sh_full ||
                (m_sample >= 0 && sample !== 8'(m_sample))) begin
                miscompares++;
                $display("FAIL sync cyc %0d: got v=%b w=%b r=%b s=%h, want v=%b w=%b r=%b s=%h",
                         c, sample_valid, wrap, cfg_ready, sample,
                         m_valid, m_wrap, !m_sh_full, m_sample);
            end
        end
        vectors++;
        if (sample !== 8'h40 || wrap !== 1'b1) begin
            miscompares++;
            $display("FAIL sync restart: got s=%h w=%b, want s=40 w=1", sample, wrap);
        end
        // Sync landing on the carry edge.
        for (int c = 0; c < 2000 && (m_acc + longint'(m_ftw)) < (longint'(1) << 24); c++) begin
            tick();
        end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            vectors++;
            if (sample_valid !== m_valid || wrap !== m_wrap || cfg_ready !== !m_sh_full ||
                (m_sample >= 0 && sample !== 8'(m_sample))) begin
                miscompares++;
                $display("FAIL sync carry cyc %0d: got v=%b w=%b s=%h, want v=%b w=%b s=%h",
                         c, sample_valid, wrap, sample, m_valid, m_wrap, m_sample);
            end
            if (sample_valid && wrap) wraps++;
        end
        vectors++;
        if (wraps !== 1) begin
            miscompares++;
            $display("FAIL sync double wrap: got %0d wraps, want 1", wraps);
        end
    endtask

    task automatic test_mid_reset();
        restart(1 << 14, 0, 1, 256);
        repeat (50) tick();
        do_cfg(1 << 15, 0, 3, 128);
        repeat (3) tick();
        #2;
        rst = 1'b0;
        en = 1'b0;
        #1;
        vectors++;
        if (sample !== 8'h80 || sample_valid !== 1'b0 || wrap !== 1'b0 || cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset: got s=%h v=%b w=%b r=%b, want s=80 v=0 w=0 r=1",
                     sample, sample_valid, wrap, cfg_ready);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        test_saw("restart");
    endtask

    task automatic test_random();
        restart(1 << 14, 0, 1, 256);
        for (int c = 0; c < 3000; c++) begin
            en        = ($urandom_range(0, 3) != 0);
            sync      = ($urandom_range(0, 49) == 0);
            cfg_valid = ($urandom_range(0, 9) == 0);
            cfg_ftw   = 24'($urandom_range(1 << 14, 1 << 19));
            cfg_poff  = 10'($urandom_range(0, 1023));
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_amp   = 9'($urandom_range(0, 511));
            tick();
            vectors++;
            if (sample_valid !== m_valid || wrap !== m_wrap || cfg_ready !== !m_sh_full ||
                (m_sample >= 0 && sample !== 8'(m_sample))) begin
                miscompares++;
                $display("FAIL random cyc %0d: got v=%b w=%b r=%b s=%h, want v=%b w=%b r=%b s=%h",
                         c, sample_valid, wrap, cfg_ready, sample,
                         m_valid, m_wrap, !m_sh_full, m_sample);
            end
        end
        sync = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_saw("saw");
        test_square();
        test_tri();
        test_handshake();
        test_sync();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
